// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit. It iterates radix-2 (one bit
//            per cycle, XLEN iterations) on operand magnitudes and applies the
//            result sign when it completes. Divide-by-zero and signed overflow
//            skip the iterations and complete after a single cycle.
// Ports    : clk     - core clock, all state on the rising edge
//            rst     - synchronous active-high reset
//            start   - request; operands are latched only when idle
//            funct3  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                      100 DIV, 101 DIVU, 110 REM, 111 REMU
//            rs1_d   - operand A
//            rs2_d   - operand B
//            rd      - destination index for this request
//            busy    - high from the accept edge through the done cycle
//            done    - one-cycle completion pulse
//            rd_d    - result, valid while done=1 and held afterwards
//            rd_out  - latched destination index
//            reg_wr  - register file write enable (done and rd_out != 0)
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int ADDR_LEN = 5,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          funct3,
  input  logic [XLEN-1:0]     rs1_d,
  input  logic [XLEN-1:0]     rs2_d,
  input  logic [ADDR_LEN-1:0] rd,
  output logic                busy,
  output logic                done,
  output logic [XLEN-1:0]     rd_d,
  output logic [ADDR_LEN-1:0] rd_out,
  output logic                reg_wr
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam int                CNT_W      = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]   c_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [2:0]          r_op;
  logic [ADDR_LEN-1:0] r_rd_out;
  logic                r_byp;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [XLEN-1:0]     r_hi;
  logic [XLEN-1:0]     r_lo;
  logic [XLEN-1:0]     r_b;
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_rd_d;

  // ---------------------------------------------------------------- decode
  logic            w_accept;
  logic            w_is_div;
  logic            w_is_rem;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_byp_val;

  assign w_accept   = (r_state == c_IDLE) && start;
  assign w_is_div   = funct3[2];
  assign w_is_rem   = funct3[2] & funct3[1];
  // rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 for MUL/MULH/DIV/REM.
  // MUL is treated as signed x signed: the low half is identical either way.
  assign w_a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign w_b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign w_a_neg    = w_a_signed & rs1_d[XLEN-1];
  assign w_b_neg    = w_b_signed & rs2_d[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~rs1_d + 1'b1) : rs1_d;
  assign w_b_mag    = w_b_neg ? (~rs2_d + 1'b1) : rs2_d;

  assign w_div_zero = w_is_div && (rs2_d == '0);
  assign w_ovf      = w_is_div && !funct3[0] && (rs1_d == c_MIN_NEG) && (rs2_d == '1);

  always_comb begin
    w_byp_val = '0;
    if (w_div_zero) begin
      w_byp_val = w_is_rem ? rs1_d : '1;
    end else if (w_ovf) begin
      w_byp_val = w_is_rem ? '0 : c_MIN_NEG;
    end
  end

  // -------------------------------------------------------- iteration step
  // Multiply: {hi,lo} is the product register, lo starts as the multiplier
  // and shifts out one bit per step while the partial sum shifts in.
  logic [XLEN:0]   w_mul_sum;
  // Divide: hi is the partial remainder, lo shifts the dividend out and the
  // quotient in. Bit XLEN of the difference is the borrow of the trial step.
  logic [XLEN:0]   w_div_shift;
  logic [XLEN:0]   w_div_diff;
  logic            w_div_ok;

  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_div_shift = {r_hi, r_lo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_div_ok    = ~w_div_diff[XLEN];

  // ------------------------------------------------------- sign and select
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_result;

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_s  = r_neg_q ? (~r_lo + 1'b1) : r_lo;
  assign w_rem_s  = r_neg_r ? (~r_hi + 1'b1) : r_hi;

  always_comb begin
    w_result = '0;
    if (r_byp) begin
      w_result = r_lo;
    end else begin
      case (r_op)
        3'b000:                 w_result = w_prod_s[XLEN-1:0];
        3'b001, 3'b010, 3'b011: w_result = w_prod_s[2*XLEN-1:XLEN];
        3'b100, 3'b101:         w_result = w_quo_s;
        default:                w_result = w_rem_s;
      endcase
    end
  end

  // ------------------------------------------------------ FSM: state reg
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ------------------------------------------------------ FSM: next state
  // Bypass requests still spend one cycle in CALC so that their result is
  // presented one cycle after the accept edge.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (start) w_next_state = c_CALC;
      c_CALC:  if (r_byp || (r_cnt == c_CNT_LAST)) w_next_state = c_DONE;
      c_DONE:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // ------------------------------------------------------ FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_CALC:  busy = 1'b1;
      c_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_out = r_rd_out;
  assign reg_wr = done & (|r_rd_out);
  // During DONE the freshly signed result is shown directly; the register
  // captures it on the way out so it stays visible until the next DONE.
  assign rd_d   = done ? w_result : r_rd_d;

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_rd_out <= '0;
      r_byp    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_rd_d   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_op     <= funct3;
            r_rd_out <= rd;
            r_byp    <= w_div_zero | w_ovf;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_hi     <= '0;
            r_lo     <= (w_div_zero | w_ovf) ? w_byp_val : w_a_mag;
            r_b      <= w_b_mag;
            r_cnt    <= '0;
          end
        end
        c_CALC: begin
          if (!r_byp) begin
            if (r_op[2]) begin
              r_hi <= w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], w_div_ok};
            end else begin
              r_hi <= w_mul_sum[XLEN:1];
              r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        c_DONE: begin
          r_rd_d <= w_result;
          r_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
